// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, baud divisor table, receiver states and hex 7-segment glyphs
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int OVERSAMPLE = 16;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] HEX_ON = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_e;
  function automatic logic [15:0] div_round(input int unsigned clk_hz, input int unsigned baud);
    return 16'((clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE));
  endfunction
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    return sel == 3'd0 ? div_round(clk_hz, 300) :
           sel == 3'd1 ? div_round(clk_hz, 1200) :
           sel == 3'd2 ? div_round(clk_hz, 4800) :
           sel == 3'd3 ? div_round(clk_hz, 9600) :
           sel == 3'd4 ? div_round(clk_hz, 19200) :
           sel == 3'd5 ? div_round(clk_hz, 38400) :
           sel == 3'd6 ? div_round(clk_hz, 57600) : div_round(clk_hz, 115200);
  endfunction
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    return ~HEX_ON[h];
  endfunction
endpackage

// File: rtl/seg7_driver.sv
// seg7_driver: holds the last good byte and multiplexes it as hex onto four active-low digits
module seg7_driver import uart_pkg::*; #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       perr,
  input  logic       ferr,
  input  logic [7:0] data,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic show_q, show_d;
  logic [7:0] shown_q, shown_d;
  logic [1:0] digit;
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    show_d = valid ? !(perr || ferr) : show_q;
    shown_d = valid && !(perr || ferr) ? data : shown_q;
    digit = refresh_q[REFRESH_BITS-1 -: 2];
    an = ~(4'b0001 << digit);
    seg = !show_q ? SEG_DASH :
          digit == 2'd0 ? hex_seg(shown_q[3:0]) :
          digit == 2'd1 ? hex_seg(shown_q[7:4]) : SEG_BLANK;
    dp = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      show_q <= 1'b0;
      shown_q <= '0;
    end else begin
      refresh_q <= refresh_d;
      show_q <= show_d;
      shown_q <= shown_d;
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversampling tick; restarting on tx start keeps bit edges aligned to the frame start
module uart_baud_gen import uart_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel,
  input  logic       sync,
  output logic       tick
);
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] sel_q;
  logic restart;
  always_comb begin
    restart = sync || sel != sel_q;
    tick = !restart && cnt_q == baud_div(CLK_HZ, sel) - 16'd1;
    cnt_d = restart || tick ? '0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling receiver with glitch rejection, parity and framing checks
module uart_rx import uart_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       line,
  output logic       valid,
  output logic [7:0] data,
  output logic       perr,
  output logic       ferr
);
  rx_state_e st_q, st_d;
  logic prev_q, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [3:0] tcnt_q, tcnt_d, bcnt_q, bcnt_d;
  logic [7:0] data_q, data_d;
  always_comb begin
    st_d = st_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    valid_d = 1'b0;
    if (!en) st_d = RX_IDLE;
    else if (st_q == RX_IDLE) begin
      if (prev_q && !line) begin
        st_d = RX_START;
        tcnt_d = '0;
      end
    end else if (tick) begin
      tcnt_d = tcnt_q + 4'd1;
      if (st_q == RX_START && tcnt_q == 4'(OVERSAMPLE / 2 - 1)) begin
        st_d = line ? RX_IDLE : RX_BITS;
        tcnt_d = '0;
        bcnt_d = '0;
      end else if (st_q == RX_BITS && tcnt_q == 4'(OVERSAMPLE - 1)) begin
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q < 4'd8) data_d = {line, data_q[7:1]};
        else if (bcnt_q == 4'd8) perr_d = line != ^data_q;
        else begin
          valid_d = 1'b1;
          ferr_d = !line;
          st_d = RX_IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= RX_IDLE;
      prev_q <= 1'b1;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      tcnt_q <= '0;
      bcnt_q <= '0;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      prev_q <= line;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
      data_q <= data_d;
    end
  end
  assign valid = valid_q;
  assign data = data_q;
  assign perr = perr_q;
  assign ferr = ferr_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 11-bit even-parity frame transmitter driven by the shared oversampling tick
module uart_tx import uart_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr,
  input  logic       tick,
  input  logic [7:0] data,
  output logic       busy,
  output logic       start,
  output logic       line
);
  logic busy_q, busy_d;
  logic [10:0] sh_q, sh_d;
  logic [3:0] tcnt_q, tcnt_d, bcnt_q, bcnt_d;
  always_comb begin
    start = en && wr && !busy_q;
    busy_d = busy_q;
    sh_d = sh_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    if (!en) busy_d = 1'b0;
    else if (start) begin
      busy_d = 1'b1;
      sh_d = {1'b1, ^data, data, 1'b0};
      tcnt_d = '0;
      bcnt_d = '0;
    end else if (busy_q && tick) begin
      tcnt_d = tcnt_q + 4'd1;
      if (tcnt_q == 4'(OVERSAMPLE - 1)) begin
        sh_d = {1'b1, sh_q[10:1]};
        bcnt_d = bcnt_q + 4'd1;
        busy_d = bcnt_q != 4'(FRAME_BITS - 1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sh_q <= '1;
      tcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      sh_q <= sh_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign busy = busy_q;
  assign line = !busy_q || sh_q[0];
endmodule

// File: rtl/uart_display_system.sv
// uart_display_system: UART tx looped back into rx, last received byte shown in hex on a 4-digit display
module uart_display_system #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_BUSY,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       AN3,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp
);
  logic tick, tx_start, serial, rx_valid, rx_perr, rx_ferr;
  logic [7:0] rx_data;
  logic [3:0] an;
  logic [6:0] seg;
  uart_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud (
    .clk(clk), .rst_n(reset), .sel(baud_select), .sync(tx_start), .tick(tick)
  );
  uart_tx u_tx (
    .clk(clk), .rst_n(reset), .en(Tx_EN), .wr(Tx_WR), .tick(tick), .data(Tx_DATA),
    .busy(Tx_BUSY), .start(tx_start), .line(serial)
  );
  uart_rx u_rx (
    .clk(clk), .rst_n(reset), .en(Rx_EN), .tick(tick), .line(serial),
    .valid(rx_valid), .data(rx_data), .perr(rx_perr), .ferr(rx_ferr)
  );
  seg7_driver #(.REFRESH_BITS(REFRESH_BITS)) u_seg (
    .clk(clk), .rst_n(reset), .valid(rx_valid), .perr(rx_perr), .ferr(rx_ferr), .data(rx_data),
    .an(an), .seg(seg), .dp(dp)
  );
  assign {AN3, AN2, AN1, AN0} = an;
  assign {a, b, c, d, e, f, g} = seg;
endmodule

// File: tb/tb_uart_display_system.sv
// tb_uart_display_system: loopback frames, busy timing, parity bits and hex display contents
module tb_uart_display_system;
  localparam logic [6:0] S_DASH = 7'b1111110, S_BLANK = 7'b1111111, S_A = 7'b0001000,
    S_5 = 7'b0100100, S_E = 7'b0110000, S_3 = 7'b0000110, S_6 = 7'b0100000, S_8 = 7'b0000000;
  typedef struct {
    logic [2:0] baud;
    int div;
    logic [7:0] data;
    logic par;
    logic [6:0] hi;
    logic [6:0] lo;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, Rx_EN = 1'b1, Tx_EN = 1'b1, Tx_WR = 1'b0;
  logic [2:0] baud_select = 3'd7;
  logic [7:0] Tx_DATA = 8'h00;
  logic Tx_BUSY, AN0, AN1, AN2, AN3, a, b, c, d, e, f, g, dp, ser;
  logic [3:0] an;
  logic [6:0] seg;
  int nvec = 0, nfail = 0, blen;
  logic ok, quiet;
  logic [10:0] bits;
  vec_t vt [3];
  always #5 clk = ~clk;
  uart_display_system #(.REFRESH_BITS(6)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .Tx_BUSY(Tx_BUSY),
    .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
  );
  assign ser = dut.serial;
  assign an = {AN3, AN2, AN1, AN0};
  assign seg = {a, b, c, d, e, f, g};
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_busy(output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      hit = Tx_BUSY;
    end
  endtask
  task automatic measure(input int div, input int wr_cycles, output int len, output logic [10:0] fr);
    len = 0;
    fr = '1;
    for (int k = 0; k < 200 * div && Tx_BUSY; k++) begin
      if (k % (16 * div) == 8 * div && k / (16 * div) < 11) fr[k / (16 * div)] = ser;
      if (k == wr_cycles) Tx_WR = 1'b0;
      len++;
      cyc();
    end
  endtask
  task automatic stay_idle(input string nm);
    logic q;
    q = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (Tx_BUSY !== 1'b0 || ser !== 1'b1) q = 1'b0;
    end
    chk(nm, 32'(q), 32'd1);
  endtask
  task automatic scan(input string nm, input logic [27:0] exp);
    logic [27:0] got;
    logic good;
    logic [3:0] seen;
    got = '1;
    good = 1'b1;
    seen = '0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      case (an)
        4'b1110: begin got[6:0] = seg; seen[0] = 1'b1; end
        4'b1101: begin got[13:7] = seg; seen[1] = 1'b1; end
        4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
        default: good = 1'b0;
      endcase
      if (dp !== 1'b1) good = 1'b0;
    end
    chk({nm, "_anodes"}, 32'({good, seen}), 32'h1f);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_digit%0d", nm, k), 32'(got[k*7 +: 7]), 32'(exp[k*7 +: 7]));
  endtask
  initial begin
    vt[0] = '{3'd7, 27, 8'hAA, 1'b0, S_A, S_A};
    vt[1] = '{3'd3, 326, 8'h5A, 1'b0, S_5, S_A};
    vt[2] = '{3'd7, 27, 8'hE3, 1'b1, S_E, S_3};
    repeat (5) cyc();
    chk("rst_busy", 32'(Tx_BUSY), 32'd0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'(S_DASH));
    chk("rst_line", 32'(ser), 32'd1);
    reset = 1'b1;
    scan("rst_scan", {S_DASH, S_DASH, S_DASH, S_DASH});
    for (int i = 0; i < 3; i++) begin
      baud_select = vt[i].baud;
      Tx_DATA = vt[i].data;
      Tx_WR = 1'b1;
      wait_busy(ok);
      chk($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
      measure(vt[i].div, 50, blen, bits);
      chk($sformatf("v%0d_busy_len", i), 32'(blen), 32'(176 * vt[i].div));
      chk($sformatf("v%0d_frame", i), 32'(bits), 32'({1'b1, vt[i].par, vt[i].data, 1'b0}));
      chk($sformatf("v%0d_parity", i), 32'(bits[9]), 32'(vt[i].par));
      stay_idle($sformatf("v%0d_one_frame", i));
      scan($sformatf("v%0d_disp", i), {S_BLANK, S_BLANK, vt[i].hi, vt[i].lo});
    end
    baud_select = 3'd7;
    Tx_DATA = 8'h68;
    Tx_WR = 1'b1;
    wait_busy(ok);
    chk("b2b_accept", 32'(ok), 32'd1);
    measure(27, -1, blen, bits);
    chk("b2b_len1", 32'(blen), 32'd4752);
    chk("b2b_frame1", 32'(bits), 32'({1'b1, 1'b1, 8'h68, 1'b0}));
    cyc();
    chk("b2b_restart", 32'(Tx_BUSY), 32'd1);
    measure(27, 50, blen, bits);
    chk("b2b_len2", 32'(blen), 32'd4752);
    chk("b2b_parity2", 32'(bits[9]), 32'd1);
    stay_idle("b2b_stop");
    scan("b2b_disp", {S_BLANK, S_BLANK, S_6, S_8});
    Tx_EN = 1'b0;
    Tx_DATA = 8'h11;
    Tx_WR = 1'b1;
    stay_idle("txen_off");
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
    scan("txen_disp", {S_BLANK, S_BLANK, S_6, S_8});
    Rx_EN = 1'b0;
    Tx_DATA = 8'h3C;
    Tx_WR = 1'b1;
    wait_busy(ok);
    chk("rxen_accept", 32'(ok), 32'd1);
    measure(27, 50, blen, bits);
    chk("rxen_len", 32'(blen), 32'd4752);
    Rx_EN = 1'b1;
    scan("rxen_disp", {S_BLANK, S_BLANK, S_6, S_8});
    Tx_DATA = 8'h42;
    Tx_WR = 1'b1;
    wait_busy(ok);
    chk("rstmid_accept", 32'(ok), 32'd1);
    repeat (20) cyc();
    Tx_WR = 1'b0;
    repeat (1500) cyc();
    reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(Tx_BUSY), 32'd0);
    chk("rstmid_line", 32'(ser), 32'd1);
    chk("rstmid_an", 32'(an), 32'hE);
    chk("rstmid_seg", 32'(seg), 32'(S_DASH));
    repeat (3) cyc();
    reset = 1'b1;
    repeat (3500) cyc();
    chk("rstmid_busy_after", 32'(Tx_BUSY), 32'd0);
    scan("rstmid_disp", {S_DASH, S_DASH, S_DASH, S_DASH});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
